// File: rtl/demux4s_pkg.sv
// ==================================================================
// demux4s_pkg : shared lane constants and the Q lane-ordering macro
// Rev 1.0
// ==================================================================
`default_nettype none

// The word is packed as {lane3, lane2, lane1, lane0}; the mux side uses the same macro.
`define DEMUX4_PACK(l3, l2, l1, l0) {l3, l2, l1, l0}

package demux4s_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

`default_nettype wire

// File: rtl/demux_lane.sv
// ==================================================================
// demux_lane : W-bit left shift register, load enable, sync clear
// Rev 1.0
// ==================================================================
`default_nettype none

module demux_lane #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] lane_q;
  logic [W-1:0] lane_d;

  // Clear with enable restarts the lane with d_i as its first (MSB-bound) bit.
  always_comb begin
    lane_d = lane_q;
    if (clr_i) begin
      lane_d = en_i ? W'(d_i) : '0;
    end else if (en_i) begin
      lane_d = (lane_q << 1) | W'(d_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign nxt_o = lane_d;

endmodule

`default_nettype wire

// File: rtl/demux4s.sv
// ==================================================================
// demux4s : serial-to-4-lane demultiplexer with valid/ack handshake
// Rev 1.0
// ==================================================================
`default_nettype none

module demux4s
  import demux4s_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             d_i,
  input  logic             sync_i,
  input  logic             ack_i,
  output logic [4*W-1:0]   q_o,
  output logic             vld_o,
  output logic             ovf_o,
  output logic [SEL_W-1:0] slot_o
);

  localparam int                BITS  = LANES * W;
  localparam int                CNT_W = $clog2(BITS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4*W-1:0]   q_q, q_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic             w_accept;
  logic             w_complete;
  logic [LANES-1:0] w_en;
  logic [W-1:0]     w_nxt [LANES];

  assign w_accept   = ce_i & ~sync_i;
  assign w_complete = w_accept && (cnt_q == LAST);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_en[i] = sync_i ? (ce_i && (i == 0))
                              : (w_accept && (cnt_q[SEL_W-1:0] == lane_sel_t'(i)));

      demux_lane #(.W(W)) u_lane (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (sync_i),
        .en_i  (w_en[i]),
        .d_i   (d_i),
        .nxt_o (w_nxt[i])
      );
    end
  endgenerate

  // Q is taken from the lanes' next values so the final bit lands in this word.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = ce_i ? CNT_W'(1) : '0;
    end else if (ce_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    q_d   = w_complete ? `DEMUX4_PACK(w_nxt[3], w_nxt[2], w_nxt[1], w_nxt[0]) : q_q;
    vld_d = w_complete | (vld_q & ~ack_i);
    ovf_d = ovf_q | (w_complete & vld_q & ~ack_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      q_q   <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o    = q_q;
  assign vld_o  = vld_q;
  assign ovf_o  = ovf_q;
  assign slot_o = cnt_q[SEL_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_demux4s.sv
// ==================================================================
// tb_demux4s : directed self-checking bench for demux4s (W=8)
// Rev 1.1
// ==================================================================
`default_nettype none

module tb_demux4s;

    localparam int W = 8;
    localparam int C_TIMEOUT_CYCLES = 20000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce = 1'b0;
    logic           d = 1'b0;
    logic           sync = 1'b0;
    logic           ack = 1'b0;
    logic [4*W-1:0] q;
    logic           vld;
    logic           ovf;
    logic [1:0]     slot;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    demux4s #(.W(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ce_i   (ce),
        .d_i    (d),
        .sync_i (sync),
        .ack_i  (ack),
        .q_o    (q),
        .vld_o  (vld),
        .ovf_o  (ovf),
        .slot_o (slot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic stream_bit(input logic [31:0] t, input int k);
        return t[(k % 4) * W + (W - 1) - (k / 4)];
    endfunction

    task automatic send_range(input logic [31:0] t, input int k0, input int k1,
                              input bit gaps, input logic ack_last);
        for (int k = k0; k <= k1; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    ce = 1'b0; d = $urandom_range(0, 1); ack = 1'b0;
                    tick();
                end
            end
            ce = 1'b1; sync = 1'b0; d = stream_bit(t, k);
            ack = (k == 31) ? ack_last : 1'b0;
            tick();
        end
        ce = 1'b0; ack = 1'b0; d = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1; ce = 1'b0;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        repeat (C_TIMEOUT_CYCLES) @(posedge clk);
        if (!done) begin
            errors++;
            $error("FAIL timeout: stimulus did not finish within %0d cycles", C_TIMEOUT_CYCLES);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        check("rst_q", q, 32'h0);
        check("rst_vld", vld, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_slot", slot, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            ce = 1'b1; d = 1'b1;
            tick();
        end
        ce = 1'b0;
        check("partial_slot", slot, 2'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_slot", slot, 2'd0);

        send_range(32'h0000_00FF, 0, 30, 1'b0, 1'b0);
        check("lane0_vld_early", vld, 1'b0);
        send_range(32'h0000_00FF, 31, 31, 1'b0, 1'b0);
        check("lane0_q", q, 32'h0000_00FF);
        check("lane0_vld", vld, 1'b1);
        check("lane0_slot", slot, 2'd0);
        do_ack();
        check("ack_vld", vld, 1'b0);
        check("ack_q_hold", q, 32'h0000_00FF);

        send_range(32'hFF00_0000, 0, 31, 1'b0, 1'b0);
        check("lane3_q", q, 32'hFF00_0000);
        check("lane3_vld", vld, 1'b1);
        do_ack();

        send_range(32'h0000_0080, 0, 31, 1'b0, 1'b0);
        check("msb_q", q, 32'h0000_0080);
        do_ack();

        send_range(32'h1234_5678, 0, 31, 1'b0, 1'b0);
        check("b2b_w1_q", q, 32'h1234_5678);
        send_range(32'hA5C3_0F96, 0, 31, 1'b0, 1'b1);
        check("b2b_w2_q", q, 32'hA5C3_0F96);
        check("b2b_vld", vld, 1'b1);
        check("b2b_ovf", ovf, 1'b0);
        do_ack();
        check("b2b_ack_vld", vld, 1'b0);

        send_range(32'hDEAD_BEEF, 0, 31, 1'b0, 1'b0);
        check("ovr_w1_ovf", ovf, 1'b0);
        send_range(32'h0F1E_2D3C, 0, 31, 1'b0, 1'b0);
        check("ovr_ovf", ovf, 1'b1);
        check("ovr_q", q, 32'h0F1E_2D3C);
        check("ovr_vld", vld, 1'b1);
        do_ack();
        check("ovr_ack_vld", vld, 1'b0);
        check("ovr_sticky", ovf, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovr_rst_ovf", ovf, 1'b0);
        check("ovr_rst_q", q, 32'h0);

        for (int i = 0; i < 10; i++) begin
            ce = 1'b1; d = $urandom_range(0, 1);
            tick();
        end
        ce = 1'b1; sync = 1'b1; d = 1'b1;
        tick();
        sync = 1'b0; ce = 1'b0;
        check("sync_slot", slot, 2'd1);
        check("sync_vld", vld, 1'b0);
        send_range(32'h3C5A_9681, 1, 31, 1'b0, 1'b0);
        check("sync_q", q, 32'h3C5A_9681);
        check("sync_vld_done", vld, 1'b1);
        do_ack();

        for (int i = 0; i < 7; i++) begin
            ce = 1'b1; d = 1'b1;
            tick();
        end
        ce = 1'b0; sync = 1'b1; d = 1'b1;
        tick();
        sync = 1'b0;
        check("syncce0_slot", slot, 2'd0);
        send_range(32'h6699_C31E, 0, 31, 1'b0, 1'b0);
        check("syncce0_q", q, 32'h6699_C31E);
        do_ack();

        send_range(32'hB7E1_5163, 0, 31, 1'b1, 1'b0);
        check("gap_q", q, 32'hB7E1_5163);
        check("gap_vld", vld, 1'b1);
        check("gap_ovf", ovf, 1'b0);
        ce = 1'b0;
        tick();
        check("gap_hold_q", q, 32'hB7E1_5163);
        check("gap_hold_vld", vld, 1'b1);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
